barrel_shift_pipe: RTL



---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_level.sv | 70 +++++++
 rtl/barrel_shift_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift mode encodings shared by the shifter pipe and the ALU decoder
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  // Right-going modes take their fill/wrap bits in at the MSB end.
  function automatic logic mode_is_right(input shift_mode_e mode);
    return mode != MODE_SLL;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one barrel-shifter stage: conditional shift by DIST plus its pipeline register
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              prev_valid,
  input  logic [WIDTH-1:0]  prev_data,
  input  logic [SHW-1:0]    prev_shamt,
  input  shift_mode_e       prev_mode,
  input  logic              prev_sign,
  input  logic [TAG_W-1:0]  prev_tag,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  output logic [SHW-1:0]    shamt,
  output shift_mode_e       mode,
  output logic              sign,
  output logic [TAG_W-1:0]  tag
);

  localparam int BIT = $clog2(DIST);
  localparam logic [WIDTH-1:0] HIGH_MASK = ~({WIDTH{1'b1}} >> DIST);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] right_fill;
  logic [WIDTH-1:0] next_data;

  // SRA fills from the sign captured at acceptance, not from the partially shifted word.
  always_comb begin
    right_fill = '0;
    if (mode_is_right(prev_mode)) begin
      if (prev_mode == MODE_SRA) right_fill = prev_sign ? HIGH_MASK : '0;
      else if (prev_mode == MODE_ROR) right_fill = prev_data << (WIDTH - DIST);
    end
    shifted = prev_data;
    case (prev_mode)
      MODE_SLL: shifted = prev_data << DIST;
      MODE_SRL,
      MODE_SRA,
      MODE_ROR: shifted = (prev_data >> DIST) | right_fill;
      default:  shifted = prev_data;
    endcase
    next_data = prev_shamt[BIT] ? shifted : prev_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      mode  <= MODE_SLL;
      sign  <= 1'b0;
      tag   <= '0;
    end else if (load) begin
      valid <= prev_valid;
      data  <= next_data;
      shamt <= prev_shamt;
      mode  <= prev_mode;
      sign  <= prev_sign;
      tag   <= prev_tag;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROR), one level per shift-amount bit
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_shamt,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  logic              p_valid [SHW];
  logic [WIDTH-1:0]  p_data  [SHW];
  logic [SHW-1:0]    p_shamt [SHW];
  shift_mode_e       p_mode  [SHW];
  logic              p_sign  [SHW];
  logic [TAG_W-1:0]  p_tag   [SHW];

  logic              s_valid [SHW];
  logic [WIDTH-1:0]  s_data  [SHW];
  logic [SHW-1:0]    s_shamt [SHW];
  shift_mode_e       s_mode  [SHW];
  logic              s_sign  [SHW];
  logic [TAG_W-1:0]  s_tag   [SHW];

  logic [SHW-1:0]    load;

  // A level loads when it is empty or its contents move on; empty levels collapse bubbles.
  always_comb begin
    load = '0;
    load[SHW-1] = !s_valid[SHW-1] || out_ready;
    for (int k = SHW - 2; k >= 0; k--) begin
      load[k] = !s_valid[k] || load[k+1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < SHW; k++) begin : g_level
    if (k == 0) begin : g_first
      assign p_valid[0] = in_valid;
      assign p_data[0]  = in_data;
      assign p_shamt[0] = in_shamt;
      assign p_mode[0]  = shift_mode_e'(in_mode);
      assign p_sign[0]  = in_data[WIDTH-1];
      assign p_tag[0]   = in_tag;
    end else begin : g_next
      assign p_valid[k] = s_valid[k-1];
      assign p_data[k]  = s_data[k-1];
      assign p_shamt[k] = s_shamt[k-1];
      assign p_mode[k]  = s_mode[k-1];
      assign p_sign[k]  = s_sign[k-1];
      assign p_tag[k]   = s_tag[k-1];
    end

    shift_level #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DIST  (1 << k),
      .SHW   (SHW)
    ) u_level (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load[k]),
      .prev_valid (p_valid[k]),
      .prev_data  (p_data[k]),
      .prev_shamt (p_shamt[k]),
      .prev_mode  (p_mode[k]),
      .prev_sign  (p_sign[k]),
      .prev_tag   (p_tag[k]),
      .valid      (s_valid[k]),
      .data       (s_data[k]),
      .shamt      (s_shamt[k]),
      .mode       (s_mode[k]),
      .sign       (s_sign[k]),
      .tag        (s_tag[k])
    );
  end

  assign out_valid = s_valid[SHW-1];
  assign out_data  = s_data[SHW-1];
  assign out_tag   = s_tag[SHW-1];

endmodule
